// File: rtl/pe_pkg.sv
// Shared constants and drain-FSM state encodings for the PE array psum path.
package pe_pkg;

  localparam int ARRAY_DIM   = 16;
  localparam int ACC_W       = 32;
  localparam int PSUM_ADDR_W = 10;
  localparam int PSUM_RD_LAT = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_FLUSH = 2'd2
  } drain_state_e;

endpackage

// File: rtl/psum_accum_buffer_if.sv
// Drain output stream: tagged psum words over valid/ready toward the output writer.
interface psum_accum_buffer_if
  import pe_pkg::*;
();

  logic [ARRAY_DIM*ACC_W-1:0] out_data;
  logic [PSUM_ADDR_W-1:0]     out_addr;
  logic                       out_valid;
  logic                       out_ready;

  modport master (output out_data, output out_addr, output out_valid, input out_ready);
  modport slave  (input out_data, input out_addr, input out_valid, output out_ready);

endinterface

// File: rtl/psum_skid_fifo.sv
// Small synchronous FIFO absorbing drain read data that is already in flight
// when the output stream stalls. Read data is zero while empty.
module psum_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (r_count != CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_next(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_next(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage has no reset; only pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/psum_accum_buffer.sv
// 1R1W partial-sum store: read-modify-write accumulation of PE results with
// write forwarding, plus a credit-limited drain of stored words to a stream.
module psum_accum_buffer
  import pe_pkg::*;
#(
  parameter int RD_LAT = PSUM_RD_LAT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [PSUM_ADDR_W-1:0]         psum_raddr,
  input  logic [PSUM_ADDR_W-1:0]         psum_waddr,
  input  logic                           psum_wen,
  input  logic                           psum_clear,
  input  logic [ARRAY_DIM*ACC_W-1:0]     pe_acc_out,
  input  logic                           pe_acc_out_valid,
  input  logic                           compute_busy,
  input  logic                           drain_start,
  input  logic [PSUM_ADDR_W:0]           drain_count,
  psum_accum_buffer_if.master            out_if,
  output logic                           drain_busy,
  output logic                           drain_done,
  output logic                           protocol_err
);

  localparam int ADDR_W     = PSUM_ADDR_W;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int WORD_W     = ARRAY_DIM * ACC_W;
  localparam int FIFO_DEPTH = RD_LAT + 2;
  localparam int FIFO_W     = ADDR_W + WORD_W;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic [WORD_W-1:0] r_mem      [DEPTH];
  logic [WORD_W-1:0] r_rd_pipe  [RD_LAT];
  logic              r_tag_vld  [RD_LAT];
  logic [ADDR_W-1:0] r_tag_addr [RD_LAT];
  logic              r_hist_vld [RD_LAT];
  logic [ADDR_W-1:0] r_hist_addr[RD_LAT];
  logic [WORD_W-1:0] r_hist_data[RD_LAT];

  drain_state_e      r_state;
  logic [ADDR_W:0]   r_drain_addr;
  logic [ADDR_W:0]   r_drain_cnt;
  logic              r_drain_busy;
  logic              r_drain_done;
  logic              r_protocol_err;

  logic [ADDR_W-1:0] w_rd_addr;
  logic [ADDR_W:0]   w_drain_addr_nxt;
  logic [WORD_W-1:0] w_old;
  logic [WORD_W-1:0] w_wdata;
  logic [CNT_W-1:0]  w_inflight;
  logic [CNT_W-1:0]  w_fifo_count;
  logic [CNT_W:0]    w_credit_used;
  logic              w_fifo_empty;
  logic [FIFO_W-1:0] w_fifo_rdata;
  logic              w_issue;
  logic              w_pop;

  // The drain only takes the read port while compute is idle.
  assign w_rd_addr        = (r_state != S_IDLE && !compute_busy) ? r_drain_addr[ADDR_W-1:0]
                                                                 : psum_raddr;
  assign w_drain_addr_nxt = r_drain_addr + {{ADDR_W{1'b0}}, 1'b1};
  assign w_credit_used    = {1'b0, w_fifo_count} + {1'b0, w_inflight};
  assign w_issue          = (r_state == S_DRAIN) && !compute_busy &&
                            (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + CNT_W'(r_tag_vld[i]);
  end

  // Walk oldest to youngest so the most recent matching write wins.
  always_comb begin
    w_old   = r_rd_pipe[RD_LAT-1];
    w_wdata = '0;
    for (int k = RD_LAT - 1; k >= 0; k--) begin
      if (r_hist_vld[k] && r_hist_addr[k] == psum_waddr) w_old = r_hist_data[k];
    end
    for (int l = 0; l < ARRAY_DIM; l++) begin
      w_wdata[l*ACC_W +: ACC_W] = psum_clear ? pe_acc_out[l*ACC_W +: ACC_W]
                                             : w_old[l*ACC_W +: ACC_W] + pe_acc_out[l*ACC_W +: ACC_W];
    end
  end

  // NOTE: the RAM and data pipelines carry no reset; valid bits live in the reset block.
  always_ff @(posedge clk) begin
    if (psum_wen) r_mem[psum_waddr] <= w_wdata;
    r_rd_pipe[0]   <= r_mem[w_rd_addr];
    r_hist_data[0] <= w_wdata;
    for (int i = 1; i < RD_LAT; i++) begin
      r_rd_pipe[i]   <= r_rd_pipe[i-1];
      r_hist_data[i] <= r_hist_data[i-1];
    end
  end

  // NOTE: all sequential state uses non-blocking assignment so stages shift cleanly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_drain_addr   <= '0;
      r_drain_cnt    <= '0;
      r_drain_busy   <= 1'b0;
      r_drain_done   <= 1'b0;
      r_protocol_err <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        r_tag_vld[i]   <= 1'b0;
        r_tag_addr[i]  <= '0;
        r_hist_vld[i]  <= 1'b0;
        r_hist_addr[i] <= '0;
      end
    end else begin
      r_tag_vld[0]   <= w_issue;
      r_tag_addr[0]  <= r_drain_addr[ADDR_W-1:0];
      r_hist_vld[0]  <= psum_wen;
      r_hist_addr[0] <= psum_waddr;
      for (int i = 1; i < RD_LAT; i++) begin
        r_tag_vld[i]   <= r_tag_vld[i-1];
        r_tag_addr[i]  <= r_tag_addr[i-1];
        r_hist_vld[i]  <= r_hist_vld[i-1];
        r_hist_addr[i] <= r_hist_addr[i-1];
      end

      if (psum_wen && !pe_acc_out_valid) r_protocol_err <= 1'b1;

      r_drain_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (drain_start) begin
            if (drain_count == '0) begin
              r_drain_done <= 1'b1;
            end else begin
              r_state      <= S_DRAIN;
              r_drain_addr <= '0;
              r_drain_cnt  <= drain_count;
              r_drain_busy <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (w_issue) begin
            r_drain_addr <= w_drain_addr_nxt;
            if (w_drain_addr_nxt == r_drain_cnt) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_fifo_empty && w_inflight == '0) begin
            r_state      <= S_IDLE;
            r_drain_busy <= 1'b0;
            r_drain_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop = !w_fifo_empty && out_if.out_ready;

  psum_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_tag_vld[RD_LAT-1]),
    .i_wdata ({r_tag_addr[RD_LAT-1], r_rd_pipe[RD_LAT-1]}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign out_if.out_valid = !w_fifo_empty;
  assign out_if.out_addr  = w_fifo_rdata[FIFO_W-1 -: ADDR_W];
  assign out_if.out_data  = w_fifo_rdata[WORD_W-1:0];
  assign drain_busy       = r_drain_busy;
  assign drain_done       = r_drain_done;
  assign protocol_err     = r_protocol_err;

endmodule

// File: tb/tb_psum_accum_buffer.sv
// Scoreboard bench for psum_accum_buffer: a lane-wise reference model of the
// psum store feeds expected drain beats into a queue checked as beats arrive.
module tb_psum_accum_buffer;
  import pe_pkg::*;

  localparam int W      = ARRAY_DIM * ACC_W;
  localparam int AW     = PSUM_ADDR_W;
  localparam int RD_LAT = 2;
  localparam int NADDR  = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic          clear;
    logic          valid;
    logic [W-1:0]  acc;
  } op_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [W-1:0]  data;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] psum_raddr;
  logic [AW-1:0] psum_waddr;
  logic          psum_wen;
  logic          psum_clear;
  logic [W-1:0]  pe_acc_out;
  logic          pe_acc_out_valid;
  logic          compute_busy;
  logic          drain_start;
  logic [AW:0]   drain_count;
  logic          drain_busy;
  logic          drain_done;
  logic          protocol_err;

  psum_accum_buffer_if u_if ();

  psum_accum_buffer #(.RD_LAT(RD_LAT)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .psum_raddr       (psum_raddr),
    .psum_waddr       (psum_waddr),
    .psum_wen         (psum_wen),
    .psum_clear       (psum_clear),
    .pe_acc_out       (pe_acc_out),
    .pe_acc_out_valid (pe_acc_out_valid),
    .compute_busy     (compute_busy),
    .drain_start      (drain_start),
    .drain_count      (drain_count),
    .out_if           (u_if),
    .drain_busy       (drain_busy),
    .drain_done       (drain_done),
    .protocol_err     (protocol_err)
  );

  always #5 clk = ~clk;

  op_t          ops_q[$];
  beat_t        sb_q[$];
  logic [W-1:0] model_mem [NADDR];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] splat(input logic [31:0] v);
    logic [W-1:0] r;
    for (int l = 0; l < ARRAY_DIM; l++) r[l*ACC_W +: ACC_W] = v;
    return r;
  endfunction

  task automatic add_op(input int addr, input bit clear, input logic [W-1:0] acc, input bit valid);
    op_t o;
    o.addr  = AW'(addr);
    o.clear = clear;
    o.valid = valid;
    o.acc   = acc;
    ops_q.push_back(o);
  endtask

  // Each op's read address leads its write by RD_LAT cycles, as the controller does.
  task automatic run_ops();
    int  n;
    op_t o;
    n = ops_q.size();
    for (int c = 0; c < n + RD_LAT; c++) begin
      @(negedge clk);
      compute_busy = 1'b1;
      psum_raddr   = (c < n) ? ops_q[c].addr : '0;
      if (c >= RD_LAT) begin
        o                = ops_q[c-RD_LAT];
        psum_wen         = 1'b1;
        psum_waddr       = o.addr;
        psum_clear       = o.clear;
        pe_acc_out       = o.acc;
        pe_acc_out_valid = o.valid;
        for (int l = 0; l < ARRAY_DIM; l++) begin
          model_mem[o.addr[3:0]][l*ACC_W +: ACC_W] = o.clear ? o.acc[l*ACC_W +: ACC_W]
              : model_mem[o.addr[3:0]][l*ACC_W +: ACC_W] + o.acc[l*ACC_W +: ACC_W];
        end
      end else begin
        psum_wen = 1'b0;
      end
    end
    @(negedge clk);
    psum_wen         = 1'b0;
    psum_clear       = 1'b0;
    pe_acc_out_valid = 1'b0;
    compute_busy     = 1'b0;
    ops_q.delete();
  endtask

  // mode 0: out_ready held high; mode 1: out_ready toggles 1,0,1,0...
  task automatic drain(input int count, input int mode, input bit preempt,
                       input bit restart, input bit thru);
    int            done_cnt = 0;
    int            beats    = 0;
    int            first    = -1;
    int            last     = -1;
    int            tail     = -1;
    bit            finished = 0;
    bit            prev_stall = 0;
    bit            rdy;
    logic [W-1:0]  held_d = '0;
    logic [AW-1:0] held_a = '0;
    beat_t         b;
    for (int a = 0; a < count; a++) begin
      b.addr = AW'(a);
      b.data = model_mem[a];
      sb_q.push_back(b);
    end
    @(negedge clk);
    drain_start     = 1'b1;
    drain_count     = (AW+1)'(count);
    u_if.out_ready  = 1'b0;
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      @(negedge clk);
      drain_start = 1'b0;
      if (cyc == 1) check("busy_after_start", W'(drain_busy), W'(count != 0));
      if (restart && cyc == 3) begin
        drain_start = 1'b1;
        drain_count = (AW+1)'(3);
      end
      compute_busy = preempt && cyc >= 4 && cyc <= 8;
      if (preempt && cyc == 8) check("preempt_no_issue", W'(u_if.out_valid), W'(0));
      rdy            = (mode == 0) ? 1'b1 : (cyc % 2 == 1);
      u_if.out_ready = rdy;
      if (prev_stall) begin
        check("hold_valid", W'(u_if.out_valid), W'(1));
        check("hold_addr", W'(u_if.out_addr), W'(held_a));
        check("hold_data", u_if.out_data, held_d);
      end
      if (u_if.out_valid && rdy) begin
        if (sb_q.size() == 0) begin
          check("extra_beat", W'(1), W'(0));
        end else begin
          b = sb_q.pop_front();
          check("beat_addr", W'(u_if.out_addr), W'(b.addr));
          check("beat_data", u_if.out_data, b.data);
        end
        beats++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      prev_stall = u_if.out_valid && !rdy;
      held_d     = u_if.out_data;
      held_a     = u_if.out_addr;
      if (drain_done) begin
        done_cnt++;
        check("done_after_last", W'(sb_q.size()), W'(0));
        if (tail < 0) tail = cyc;
      end
      if (tail >= 0 && cyc >= tail + 3) finished = 1;
    end
    if (!finished) check("drain_timeout", W'(0), W'(1));
    check("done_pulses", W'(done_cnt), W'(1));
    check("beat_count", W'(beats), W'(count));
    check("busy_end", W'(drain_busy), W'(0));
    if (thru) check("throughput", W'(last - first), W'(count - 1));
    sb_q.delete();
    u_if.out_ready = 1'b0;
    compute_busy   = 1'b0;
  endtask

  initial begin
    logic [W-1:0] wv;
    int           seen_done;
    rst_n            = 1'b0;
    psum_raddr       = '0;
    psum_waddr       = '0;
    psum_wen         = 1'b0;
    psum_clear       = 1'b0;
    pe_acc_out       = '0;
    pe_acc_out_valid = 1'b0;
    compute_busy     = 1'b0;
    drain_start      = 1'b0;
    drain_count      = '0;
    u_if.out_ready   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", W'(u_if.out_valid), W'(0));
    check("rst_out_data", u_if.out_data, '0);
    check("rst_drain_busy", W'(drain_busy), W'(0));
    check("rst_drain_done", W'(drain_done), W'(0));
    check("rst_protocol_err", W'(protocol_err), W'(0));

    // Give every address a defined, distinct starting value.
    for (int a = 0; a < NADDR; a++) begin
      for (int l = 0; l < ARRAY_DIM; l++) wv[l*ACC_W +: ACC_W] = 32'(a * 100 + l);
      add_op(a, 1'b1, wv, 1'b1);
    end
    run_ops();

    // Clear then accumulate in separate bursts: addr 5 -> 13.
    add_op(5, 1'b1, splat(32'd10), 1'b1);
    run_ops();
    add_op(5, 1'b0, splat(32'd3), 1'b1);
    run_ops();

    // Back-to-back same-address writes exercise both forwarding stages: addr 7 -> 7.
    add_op(7, 1'b1, splat(32'd1), 1'b1);
    add_op(7, 1'b0, splat(32'd2), 1'b1);
    add_op(7, 1'b0, splat(32'd4), 1'b1);
    // Cycle-2-only forwarding on addr 3.
    add_op(3, 1'b0, splat(32'd5), 1'b1);
    add_op(4, 1'b0, splat(32'd6), 1'b1);
    add_op(3, 1'b0, splat(32'd7), 1'b1);
    run_ops();

    // Modulo wrap per lane.
    wv = splat(32'h8000_0000);
    wv[0*ACC_W +: ACC_W] = 32'h7FFF_FFFF;
    wv[1*ACC_W +: ACC_W] = 32'hFFFF_FFFF;
    add_op(9, 1'b1, wv, 1'b1);
    add_op(9, 1'b0, splat(32'd1), 1'b1);
    run_ops();
    @(negedge clk);
    check("no_protocol_err", W'(protocol_err), W'(0));

    drain(6, 0, 1'b0, 1'b0, 1'b0);
    drain(10, 0, 1'b0, 1'b0, 1'b0);
    drain(8, 1, 1'b0, 1'b1, 1'b0);
    drain(8, 0, 1'b1, 1'b0, 1'b0);
    drain(0, 0, 1'b0, 1'b0, 1'b0);

    // Random accumulation with dense address collisions.
    for (int i = 0; i < 40; i++) begin
      for (int l = 0; l < ARRAY_DIM; l++) wv[l*ACC_W +: ACC_W] = $urandom;
      add_op((i < 20) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15)),
             ($urandom_range(0, 7) == 0), wv, 1'b1);
    end
    run_ops();
    drain(16, 0, 1'b0, 1'b0, 1'b1);

    // Reset in the middle of a drain.
    @(negedge clk);
    drain_start    = 1'b1;
    drain_count    = (AW+1)'(8);
    u_if.out_ready = 1'b0;
    repeat (4) begin
      @(negedge clk);
      drain_start = 1'b0;
    end
    check("pre_reset_valid", W'(u_if.out_valid), W'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_out_valid", W'(u_if.out_valid), W'(0));
    check("mid_rst_drain_busy", W'(drain_busy), W'(0));
    check("mid_rst_drain_done", W'(drain_done), W'(0));
    seen_done = 0;
    repeat (8) begin
      @(negedge clk);
      if (drain_done || u_if.out_valid) seen_done++;
    end
    check("post_rst_quiet", W'(seen_done), W'(0));

    // Write without a valid PE result: still written, error is sticky.
    add_op(2, 1'b0, splat(32'd9), 1'b0);
    run_ops();
    @(negedge clk);
    check("protocol_err_set", W'(protocol_err), W'(1));
    add_op(11, 1'b0, splat(32'd1), 1'b1);
    run_ops();
    repeat (5) @(negedge clk);
    check("protocol_err_sticky", W'(protocol_err), W'(1));

    // Contents survive reset; the unqualified write landed.
    drain(16, 0, 1'b0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
